// File: rtl/gip_boot_rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gip_boot_rom_arb_pkg
//
// Purpose : Shared types and constants for the GIP boot ROM arbiter.
//           - owner_t identifies which requester a ROM read belongs to.
//           - BOOT_ROM_ARB_LATENCY is the ack-to-data_valid latency in cycles.
//           - grant_owner() maps a granted port to its owner tag.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package gip_boot_rom_arb_pkg;

   localparam int BOOT_ROM_ADDR_W      = 12;
   localparam int BOOT_ROM_DATA_W      = 32;
   localparam int BOOT_ROM_ARB_LATENCY = 3;
   localparam int NUM_PORTS            = 2;

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_t;

   function automatic owner_t grant_owner(input logic data_granted);
      return data_granted ? OWNER_DATA : OWNER_FETCH;
   endfunction

endpackage

// File: rtl/gip_boot_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// gip_boot_rom_arbiter_if
//
// Purpose : Bundles the requester-side handshakes (fetch and data ports) and
//           the ROM-side signals of the boot ROM arbiter.
// Modports:
//   slave  - the arbiter: takes req/address/rom_read_data, drives acks,
//            data valids, read_data, rom_address, rom_read.
//   master - the environment (front ends plus ROM): the mirror image.
// Signals :
//   fetch_req/fetch_address/fetch_ack/fetch_data_valid  fetch port
//   data_req/data_address/data_ack/data_data_valid      data port
//   read_data                                           shared returned word
//   rom_address/rom_read/rom_read_data                  boot ROM side
// -----------------------------------------------------------------------------
interface gip_boot_rom_arbiter_if
   import gip_boot_rom_arb_pkg::*;
#(
   parameter int ADDR_W = BOOT_ROM_ADDR_W,
   parameter int DATA_W = BOOT_ROM_DATA_W
);

   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_address;
   logic              fetch_ack;
   logic              fetch_data_valid;

   logic              data_req;
   logic [ADDR_W-1:0] data_address;
   logic              data_ack;
   logic              data_data_valid;

   logic [DATA_W-1:0] read_data;

   logic [ADDR_W-1:0] rom_address;
   logic              rom_read;
   logic [DATA_W-1:0] rom_read_data;

   modport slave (
      input  fetch_req, fetch_address, data_req, data_address, rom_read_data,
      output fetch_ack, fetch_data_valid, data_ack, data_data_valid,
             read_data, rom_address, rom_read
   );

   modport master (
      output fetch_req, fetch_address, data_req, data_address, rom_read_data,
      input  fetch_ack, fetch_data_valid, data_ack, data_data_valid,
             read_data, rom_address, rom_read
   );

endinterface

// File: rtl/gip_boot_rom_arbiter_rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// gip_rr_arbiter_2
//
// Purpose : Two-input grant logic for the boot ROM arbiter.
//           Macro BOOT_ROM_ARB_ROUND_ROBIN_EN:
//             defined   - two-way round robin. On contention the port named by
//                         the priority pointer wins; after any grant the
//                         pointer moves to the other port. Pointer resets to
//                         the fetch port.
//             undefined - fixed priority, data port always wins; no pointer
//                         state exists, so clk/rst ports are not present.
// Ports   :
//   clk, rst      clock and asynchronous active-high reset (round robin only)
//   req_fetch     fetch port request
//   req_data      data port request
//   grant_fetch   fetch port wins this cycle (combinational)
//   grant_data    data port wins this cycle (combinational)
// -----------------------------------------------------------------------------
module gip_rr_arbiter_2
   import gip_boot_rom_arb_pkg::*;
(
`ifdef BOOT_ROM_ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic rst,
`endif
   input  logic req_fetch,
   input  logic req_data,
   output logic grant_fetch,
   output logic grant_data
);

`ifdef BOOT_ROM_ARB_ROUND_ROBIN_EN

   // Port that wins when both request in the same cycle.
   owner_t prio_reg;

   assign grant_fetch = req_fetch & (~req_data  | (prio_reg == OWNER_FETCH));
   assign grant_data  = req_data  & (~req_fetch | (prio_reg == OWNER_DATA));

   // The pointer flips on every grant, contended or not, so a port that just
   // won always yields the next contended cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_reg <= OWNER_FETCH;
      end else if (grant_fetch) begin
         prio_reg <= OWNER_DATA;
      end else if (grant_data) begin
         prio_reg <= OWNER_FETCH;
      end
   end

`else

   assign grant_data  = req_data;
   assign grant_fetch = req_fetch & ~req_data;

`endif

endmodule

// File: rtl/gip_boot_rom_arbiter.sv
// -----------------------------------------------------------------------------
// gip_boot_rom_arbiter
//
// Purpose : Shares the single-ported GIP boot ROM between the instruction-fetch
//           port and the data-read port. One read can be issued per cycle;
//           each read returns exactly BOOT_ROM_ARB_LATENCY cycles after its
//           ack, in issue order, tagged with the owning port's data_valid.
//           Arbitration policy selected by macro BOOT_ROM_ARB_ROUND_ROBIN_EN
//           (defined: round robin, undefined: data port fixed priority).
// Ports   :
//   rom_clock  sole clock, all state on rising edge
//   rom_reset  asynchronous active-high reset; discards in-flight reads and
//              forces both acks low while asserted
//   bus        gip_boot_rom_arbiter_if.slave
//                fetch_req/fetch_address -> fetch_ack (comb), fetch_data_valid
//                data_req/data_address   -> data_ack (comb), data_data_valid
//                read_data               registered word for the owning port
//                rom_address/rom_read    registered ROM command
//                rom_read_data           ROM output, valid cycle after rom_read
// -----------------------------------------------------------------------------
module gip_boot_rom_arbiter
   import gip_boot_rom_arb_pkg::*;
#(
   parameter int ADDR_W = BOOT_ROM_ADDR_W,
   parameter int DATA_W = BOOT_ROM_DATA_W
) (
   input logic                   rom_clock,
   input logic                   rom_reset,
   gip_boot_rom_arbiter_if.slave bus
);

   // Stages between ack and the output register: stage 0 is the ROM command
   // register, the last stage lines up with rom_read_data.
   localparam int PIPE_D = BOOT_ROM_ARB_LATENCY - 1;

   logic                 grant_fetch;
   logic                 grant_data;
   logic                 fetch_ack;
   logic                 data_ack;
   logic                 any_ack;
   owner_t               owner_next;
   logic [ADDR_W-1:0]    rom_address_next;
   logic [ADDR_W-1:0]    rom_address_reg;
   logic [PIPE_D-1:0]    valid_pipe_reg;
   owner_t               owner_pipe_reg [PIPE_D];
   logic [DATA_W-1:0]    read_data_reg;
   logic [NUM_PORTS-1:0] port_valid_next;
   logic [NUM_PORTS-1:0] port_valid_reg;

   gip_rr_arbiter_2 u_arb (
`ifdef BOOT_ROM_ARB_ROUND_ROBIN_EN
      .clk         (rom_clock),
      .rst         (rom_reset),
`endif
      .req_fetch   (bus.fetch_req),
      .req_data    (bus.data_req),
      .grant_fetch (grant_fetch),
      .grant_data  (grant_data)
   );

   // Acks are combinational from the requests; reset masks them so nothing
   // is accepted while the pipeline is being cleared.
   assign fetch_ack        = grant_fetch & ~rom_reset;
   assign data_ack         = grant_data  & ~rom_reset;
   assign any_ack          = fetch_ack | data_ack;
   assign owner_next       = grant_owner(data_ack);
   assign rom_address_next = data_ack ? bus.data_address : bus.fetch_address;

   // ROM command register plus the owner/valid tag pipeline.
   always_ff @(posedge rom_clock or posedge rom_reset) begin
      if (rom_reset) begin
         valid_pipe_reg  <= '0;
         rom_address_reg <= '0;
         for (int i = 0; i < PIPE_D; i++) begin
            owner_pipe_reg[i] <= OWNER_FETCH;
         end
      end else begin
         valid_pipe_reg    <= {valid_pipe_reg[PIPE_D-2:0], any_ack};
         owner_pipe_reg[0] <= owner_next;
         for (int i = 1; i < PIPE_D; i++) begin
            owner_pipe_reg[i] <= owner_pipe_reg[i-1];
         end
         // Address holds its last value on idle cycles.
         if (any_ack) begin
            rom_address_reg <= rom_address_next;
         end
      end
   end

   // Decode the aligned owner tag into one valid strobe per port.
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_valid
         assign port_valid_next[gi] = valid_pipe_reg[PIPE_D-1] &
                                      (owner_pipe_reg[PIPE_D-1] == owner_t'(1'(gi)));
      end
   endgenerate

   // Output register: read_data only moves when a read actually returns.
   always_ff @(posedge rom_clock or posedge rom_reset) begin
      if (rom_reset) begin
         read_data_reg  <= '0;
         port_valid_reg <= '0;
      end else begin
         port_valid_reg <= port_valid_next;
         if (valid_pipe_reg[PIPE_D-1]) begin
            read_data_reg <= bus.rom_read_data;
         end
      end
   end

   assign bus.fetch_ack        = fetch_ack;
   assign bus.data_ack         = data_ack;
   assign bus.rom_read         = valid_pipe_reg[0];
   assign bus.rom_address      = rom_address_reg;
   assign bus.read_data        = read_data_reg;
   assign bus.fetch_data_valid = port_valid_reg[OWNER_FETCH];
   assign bus.data_data_valid  = port_valid_reg[OWNER_DATA];

endmodule

// File: tb/tb_gip_boot_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gip_boot_rom_arbiter
//
// Purpose : Self-checking bench for gip_boot_rom_arbiter. A behavioural ROM
//           supplies a distinct word per address; a reference model predicts
//           grants from the arbitration rules and keeps a queue of issued
//           reads with their due cycle. Follows BOOT_ROM_ARB_ROUND_ROBIN_EN
//           the same way the design does.
// -----------------------------------------------------------------------------
module tb_gip_boot_rom_arbiter;
   import gip_boot_rom_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   gip_boot_rom_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   gip_boot_rom_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
      .rom_clock (clk),
      .rom_reset (rst),
      .bus       (bus)
   );

   function automatic logic [31:0] rom_word(input logic [11:0] a);
      return {4'hB, a, 4'h5, ~a};
   endfunction

   // Behavioural boot ROM: one-cycle synchronous read.
   always @(posedge clk) begin
      if (bus.rom_read) bus.rom_read_data <= rom_word(bus.rom_address);
   end

   // ---------------- reference model state ----------------
   typedef struct {
      bit         own_data;
      logic [11:0] addr;
      int         due;
   } ret_t;

   ret_t        ret_q[$];
   int          cyc;
   logic        exp_rom_read;
   logic [11:0] exp_rom_addr;
   logic [31:0] exp_rd;
`ifdef BOOT_ROM_ARB_ROUND_ROBIN_EN
   bit          prio_data;   // 1: data port wins the next contended cycle
`endif

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h cycle=%0d", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, advance model at
   // the following posedge.
   task automatic step(input logic fr, input logic [11:0] fa,
                       input logic dr, input logic [11:0] da,
                       output bit gf, output bit gd);
      bit   ef, ed, efv, edv;
      ret_t r;
      bus.fetch_req     = fr;
      bus.fetch_address = fa;
      bus.data_req      = dr;
      bus.data_address  = da;
      @(negedge clk);
      if (fr && dr) begin
`ifdef BOOT_ROM_ARB_ROUND_ROBIN_EN
         ed = prio_data;
         ef = !prio_data;
`else
         ed = 1'b1;
         ef = 1'b0;
`endif
      end else begin
         ef = fr;
         ed = dr;
      end
      check_eq("fetch_ack", 32'(bus.fetch_ack), 32'(ef));
      check_eq("data_ack", 32'(bus.data_ack), 32'(ed));
      check_eq("rom_read", 32'(bus.rom_read), 32'(exp_rom_read));
      check_eq("rom_address", 32'(bus.rom_address), 32'(exp_rom_addr));
      efv = 1'b0;
      edv = 1'b0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
         r = ret_q.pop_front();
         if (r.own_data) edv = 1'b1;
         else            efv = 1'b1;
         exp_rd = rom_word(r.addr);
         $display("RET cycle=%0d port=%s addr=0x%03h word=0x%08h", cyc,
                  r.own_data ? "data" : "fetch", r.addr, bus.read_data);
      end
      check_eq("fetch_data_valid", 32'(bus.fetch_data_valid), 32'(efv));
      check_eq("data_data_valid", 32'(bus.data_data_valid), 32'(edv));
      check_eq("read_data", bus.read_data, exp_rd);
      @(posedge clk);
      cyc++;
      exp_rom_read = ef | ed;
      if (ef | ed) begin
         exp_rom_addr = ed ? da : fa;
         ret_q.push_back('{own_data: ed, addr: (ed ? da : fa), due: cyc + BOOT_ROM_ARB_LATENCY - 1});
`ifdef BOOT_ROM_ARB_ROUND_ROBIN_EN
         prio_data = ef;
`endif
      end
      gf = ef;
      gd = ed;
      #1;
   endtask

   task automatic idle(input int n);
      bit gf, gd;
      for (int i = 0; i < n; i++) step(1'b0, 12'h000, 1'b0, 12'h000, gf, gd);
   endtask

   // Asserts reset right now (posedge+1), with a fetch request pending to
   // show acks are masked, and releases it two cycles later at a negedge.
   task automatic reset_mid();
      bus.fetch_req     = 1'b1;
      bus.fetch_address = 12'h3C3;
      bus.data_req      = 1'b1;
      bus.data_address  = 12'h5A5;
      rst = 1'b1;
      #1;
      ret_q.delete();
      exp_rom_read = 1'b0;
      exp_rom_addr = 12'h000;
      exp_rd       = 32'h0;
`ifdef BOOT_ROM_ARB_ROUND_ROBIN_EN
      prio_data = 1'b0;
`endif
      check_eq("rst_rom_address", 32'(bus.rom_address), 32'h0);
      check_eq("rst_read_data", bus.read_data, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("rst_fetch_ack", 32'(bus.fetch_ack), 32'h0);
         check_eq("rst_data_ack", 32'(bus.data_ack), 32'h0);
         check_eq("rst_rom_read", 32'(bus.rom_read), 32'h0);
         check_eq("rst_valids", 32'({bus.fetch_data_valid, bus.data_data_valid}), 32'h0);
      end
      bus.fetch_req = 1'b0;
      bus.data_req  = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      bit          gf, gd;
      int          nf, nd;
      logic        fr, dr;
      logic [11:0] fa, da;
      cyc = 0;
      bus.fetch_req     = 1'b0;
      bus.fetch_address = 12'h000;
      bus.data_req      = 1'b0;
      bus.data_address  = 12'h000;
      #1;
      reset_mid();

      // Single fetch of 0x010.
      step(1'b1, 12'h010, 1'b0, 12'h000, gf, gd);
      idle(4);

      // Both ports hold requests for 6 cycles; each moves to its next
      // address only once acked. Then data drops and fetch keeps asking.
      nf = 0;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 12'(12'h100 + nf), 1'b1, 12'(12'h800 + nd), gf, gd);
         nf += int'(gf);
         nd += int'(gd);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 12'(12'h100 + nf), 1'b0, 12'h000, gf, gd);
         nf += int'(gf);
      end
      idle(4);

      // Back-to-back fetches 0x000..0x007.
      for (int i = 0; i < 8; i++) step(1'b1, 12'(i), 1'b0, 12'h000, gf, gd);
      idle(4);

      // Data read killed by reset two cycles after its ack.
      step(1'b0, 12'h000, 1'b1, 12'h234, gf, gd);
      idle(1);
      reset_mid();
      step(1'b1, 12'h055, 1'b1, 12'h0AA, gf, gd);
      idle(5);

      // Long idle stretch.
      idle(10);

      // Randomized traffic with one reset in the middle.
      for (int i = 0; i < 300; i++) begin
         if (i == 150) reset_mid();
         fr = ($urandom_range(0, 99) < 60);
         dr = ($urandom_range(0, 99) < 55);
         fa = 12'($urandom_range(0, 4095));
         da = 12'($urandom_range(0, 4095));
         step(fr, fa, dr, da, gf, gd);
      end
      idle(5);
      check_eq("drained", 32'(ret_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gip_boot_rom_arbiter.md
# gip_boot_rom_arbiter

Shares the single-ported GIP boot ROM (12-bit word address, 32-bit data, one-cycle synchronous read) between the instruction-fetch port and the data-read port. Each requester presents a request/address, gets a same-cycle acknowledge when granted, and later receives a tagged data-valid strobe with the word. The block is fully pipelined and sustains one ROM read per cycle. It sits between the GIP core's fetch/data front ends and the boot ROM instance.

## Interface
- ADDR_W, 12, ROM word-address width
- DATA_W, 32, ROM data width

- rom_clock  in  1  sole clock; all state on rising edge
- rom_reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch port requests a read this cycle
- fetch_address  in  ADDR_W  fetch word address, valid with fetch_req
- fetch_ack  out  1  combinational; fetch request accepted this cycle
- fetch_data_valid  out  1  read_data holds the fetch port's word
- data_req  in  1  data port requests a read this cycle
- data_address  in  ADDR_W  data word address, valid with data_req
- data_ack  out  1  combinational; data request accepted this cycle
- data_data_valid  out  1  read_data holds the data port's word
- read_data  out  DATA_W  registered returned word, shared by both ports
- rom_address  out  ADDR_W  registered address to ROM
- rom_read  out  1  registered ROM read enable
- rom_read_data  in  DATA_W  ROM output, valid the cycle after rom_read

## Operation
- Arbitration each cycle on fetch_req/data_req; at most one ack per cycle; ack = req & grant.
- A request is consumed only in a cycle where its ack is high; requester must present next request (or drop req) after that edge. A req held high across several acked cycles issues one read per acked cycle.
- Grant registers rom_read=1, rom_address=granted address, owner tag. No grant: rom_read=0, rom_address holds last value.
- Owner tag and valid delayed one stage to align with rom_read_data; then read_data<=rom_read_data and exactly one of fetch_data_valid/data_data_valid set for one cycle.
- When no read returns, read_data holds last value; both valids low.
- Returns are in issue order; no reordering, no stalling (requesters must accept data_valid unconditionally).
- Reset (any cycle, asynchronous): in-flight reads discarded, no valid emitted for them. Reset values: rom_read=0, rom_address=0, read_data=0, fetch_data_valid=0, data_data_valid=0, priority pointer=fetch. fetch_ack/data_ack forced low while rom_reset high.

## Timing
- Cycle N: req high, ack high (combinational).
- N+1: rom_read=1, rom_address=request address.
- N+2: rom_read_data valid from ROM; tag aligned.
- N+3: read_data and owning *_data_valid asserted. Latency 3 cycles from ack to valid.
- Throughput 1 read/cycle; alternate grants interleave returns cycle-by-cycle.

## Configuration
- BOOT_ROM_ARB_ROUND_ROBIN_EN defined: two-way round robin; when both request, grant port indicated by priority pointer; after any grant pointer moves to the other port. Single requester always granted. Reset pointer = fetch.
- Undefined: fixed priority, data port always wins; fetch granted only when data_req low; pointer not implemented.

## Structure
- Package gip_boot_rom_arb_pkg: owner tag type (OWNER_FETCH=0, OWNER_DATA=1), constant BOOT_ROM_ARB_LATENCY=3.
- One natural sub-module: gip_rr_arbiter_2 (two-input grant logic plus pointer, pointer compiled per macro). Tag/valid pipeline lives in the top.

## Test plan
- Reset, then fetch_req=1 addr 0x010 for one cycle -> fetch_ack same cycle, rom_read/rom_address=0x010 at N+1, read_data=ROM[0x010] with fetch_data_valid at N+3, data_data_valid stays 0.
- Both req held 6 cycles, fetch 0x100.., data 0x800.. (RR_EN) -> acks alternate fetch,data,fetch…; valids alternate at N+3 onward with correct words.
- Same stimulus without macro -> data_ack every cycle, fetch_ack never; fetch granted first cycle after data_req drops.
- Back-to-back fetch, addresses 0x000–0x007 over 8 cycles -> 8 consecutive fetch_data_valid cycles, words in order.
- Assert rom_reset at N+2 of an outstanding data read -> no data_data_valid ever for it; outputs at reset values; first request after release returns normally with 3-cycle latency.
- No requests 10 cycles -> rom_read=0, both valids 0, read_data unchanged.
